// File: rtl/md5_job_scheduler.sv
// Round-robin scheduler sharing one MD5 accelerator: grant, start, read routing, digest gather, watchdog abort.
// gnt one cycle after a request is seen in IDLE, acc_start one cycle later; new requests wait while busy (no preemption).
module md5_job_scheduler #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1024,
    parameter int TMR_W   = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [N_REQ-1:0]  done,
    output logic [N_REQ-1:0]  err,
    output logic              busy,
    output logic [ID_W-1:0]   owner,
    output logic [127:0]      hash_out,
    output logic              hash_valid,
    output logic              acc_start,
    output logic              acc_reset,
    input  logic [3:0]        acc_msg_addr,
    input  logic              acc_mem_read,
    input  logic [31:0]       acc_hash,
    input  logic              acc_valid,
    output logic [ID_W+3:0]   mem_addr,
    output logic              mem_read
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

    state_t                 state;
    state_t                 state_nx;
    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        ptr_nx;
    logic [ID_W-1:0]        id;
    logic [ID_W-1:0]        id_nx;
    logic [ID_W-1:0]        pick;
    logic                   pick_vld;
    logic [2:0]             cnt;
    logic [2:0]             cnt_nx;
    logic [TMR_W-1:0]       timer;
    logic [TMR_W-1:0]       timer_nx;
    logic [3:0][31:0]       words;
    logic [3:0][31:0]       words_nx;

    // Search starts just after the last served id, so that id ends up with lowest priority.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!pick_vld && req[ptr + ID_W'(i)]) begin
                pick     = ptr + ID_W'(i);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        id_nx    = id;
        cnt_nx   = cnt;
        timer_nx = timer;
        words_nx = words;
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    id_nx    = pick;
                    state_nx = S_GRANT;
                end
            end
            S_GRANT: begin
                cnt_nx   = '0;
                timer_nx = '0;
                state_nx = S_START;
            end
            S_START: begin
                state_nx = S_RUN;
            end
            S_RUN: begin
                timer_nx = timer + TMR_W'(1);
                if (acc_valid) begin
                    words_nx[cnt[1:0]] = acc_hash;
                    cnt_nx             = cnt + 3'd1;
                end
                // A fourth word landing on the last allowed cycle still completes the job.
                if (acc_valid && cnt == 3'd3) begin
                    state_nx = S_DONE;
                end else if (timer == TMR_LAST) begin
                    state_nx = S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                ptr_nx   = id;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so each pulse lines up with its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ptr        <= ID_W'(N_REQ - 1);
            id         <= '0;
            cnt        <= '0;
            timer      <= '0;
            words      <= '0;
            gnt        <= '0;
            done       <= '0;
            err        <= '0;
            busy       <= 1'b0;
            owner      <= '0;
            hash_out   <= '0;
            hash_valid <= 1'b0;
            acc_start  <= 1'b0;
            acc_reset  <= 1'b0;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            id         <= id_nx;
            cnt        <= cnt_nx;
            timer      <= timer_nx;
            words      <= words_nx;
            gnt        <= (state_nx == S_GRANT) ? (ONE << id_nx) : '0;
            done       <= (state_nx == S_DONE) ? (ONE << id) : '0;
            err        <= (state_nx == S_ERR) ? (ONE << id) : '0;
            busy       <= (state_nx != S_IDLE);
            hash_valid <= (state_nx == S_DONE);
            acc_start  <= (state_nx == S_START);
            acc_reset  <= (state_nx == S_ERR);
            if (state_nx == S_GRANT) begin
                owner <= id_nx;
            end
            if (state_nx == S_DONE) begin
                hash_out <= {words_nx[0], words_nx[1], words_nx[2], words_nx[3]};
            end
        end
    end

    assign mem_read = (state == S_RUN) && acc_mem_read;
    assign mem_addr = (state == S_RUN) ? {id, acc_msg_addr} : {owner, 4'h0};

endmodule

// File: tb/tb_md5_job_scheduler.sv
// Randomized bench for md5_job_scheduler: accelerator model plus round-robin/digest reference.
module tb_md5_job_scheduler;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 32;
    localparam int TMR_W   = 6;

    localparam int K_GNT   = 0;
    localparam int K_START = 1;
    localparam int K_DONE  = 2;
    localparam int K_ERR   = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [3:0]   gnt;
    logic [3:0]   done;
    logic [3:0]   err;
    logic         busy;
    logic [1:0]   owner;
    logic [127:0] hash_out;
    logic         hash_valid;
    logic         acc_start;
    logic         acc_reset;
    logic [3:0]   acc_msg_addr;
    logic         acc_mem_read;
    logic [31:0]  acc_hash;
    logic         acc_valid;
    logic [5:0]   mem_addr;
    logic         mem_read;

    md5_job_scheduler #(
        .N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt), .done(done), .err(err),
        .busy(busy), .owner(owner), .hash_out(hash_out), .hash_valid(hash_valid),
        .acc_start(acc_start), .acc_reset(acc_reset), .acc_msg_addr(acc_msg_addr),
        .acc_mem_read(acc_mem_read), .acc_hash(acc_hash), .acc_valid(acc_valid),
        .mem_addr(mem_addr), .mem_read(mem_read)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           kind;
        logic [3:0]   vec;
        int           cyc;
        logic [127:0] hash;
        logic         hv;
        logic         ar;
        logic [1:0]   own;
        logic         bsy;
    } ev_t;

    ev_t          ev_q[$];
    logic [5:0]   addr_q[$];
    int           cyc = 0;
    int           tests_run = 0;
    int           tests_failed = 0;
    int           gnt_total = 0;
    int           done_total = 0;
    int           err_total = 0;
    int           acc_mode = 0;      // 0 normal, 1 silent, 2 fourth word on last allowed cycle
    bit           fixed_words = 1'b0;
    logic [127:0] exp_digest = '0;
    int           job_last_r = 0;
    int           model_last = N_REQ - 1;
    logic [127:0] model_hash = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        ev_t e;
        e.cyc  = cyc;
        e.hash = hash_out;
        e.hv   = hash_valid;
        e.ar   = acc_reset;
        e.own  = owner;
        e.bsy  = busy;
        e.vec  = '0;
        if (gnt != 0)  begin e.kind = K_GNT;  e.vec = gnt;  ev_q.push_back(e); gnt_total++;  end
        if (acc_start) begin e.kind = K_START; e.vec = '0;  ev_q.push_back(e); end
        if (done != 0) begin e.kind = K_DONE; e.vec = done; ev_q.push_back(e); done_total++; end
        if (err != 0)  begin e.kind = K_ERR;  e.vec = err;  ev_q.push_back(e); err_total++;  end
    end

    // Accelerator model: 16 message reads, then the hash words with random gaps.
    always begin : acc_model
        int          vr [6];
        logic [31:0] w [6];
        int          maxr;
        @(negedge clk);
        if (reset && acc_start) begin
            for (int k = 0; k < 6; k++) begin
                w[k]  = $urandom;
                vr[k] = -1;
            end
            if (fixed_words) begin
                w[0] = 32'h11111111; w[1] = 32'h22222222;
                w[2] = 32'h33333333; w[3] = 32'h44444444;
            end
            if (acc_mode == 0) begin
                vr[0] = 17 + int'($urandom_range(0, 3));
                for (int k = 1; k < 4; k++) vr[k] = vr[k-1] + 1 + int'($urandom_range(0, 1));
                vr[4] = vr[3] + 1;
                vr[5] = vr[3] + 2;
                maxr  = vr[5];
            end else if (acc_mode == 2) begin
                for (int k = 0; k < 6; k++) vr[k] = TIMEOUT - 3 + k;
                maxr = vr[5];
            end else begin
                maxr = TIMEOUT;
            end
            exp_digest = {w[0], w[1], w[2], w[3]};
            job_last_r = vr[3];
            for (int r = 1; r <= maxr + 1; r++) begin
                @(negedge clk);
                if (!reset) break;
                acc_mem_read = (r <= 16);
                acc_msg_addr = (r <= 16) ? 4'(r - 1) : 4'h0;
                acc_valid    = 1'b0;
                acc_hash     = '0;
                for (int k = 0; k < 6; k++) begin
                    if (vr[k] == r) begin
                        acc_valid = 1'b1;
                        acc_hash  = w[k];
                    end
                end
                if (r <= 16) begin
                    #1;
                    addr_q.push_back(mem_addr);
                end
            end
            acc_mem_read = 1'b0;
            acc_valid    = 1'b0;
            acc_msg_addr = '0;
            acc_hash     = '0;
        end
    end

    function automatic int rr_pick(input int last, input logic [3:0] r);
        int sel = -1;
        for (int k = 1; k <= N_REQ; k++) begin
            if (sel < 0 && r[(last + k) % N_REQ]) sel = (last + k) % N_REQ;
        end
        return sel;
    endfunction

    task automatic wait_ev(input int kind, input int budget, output ev_t e, output bit ok);
        int n = 0;
        ok = 1'b0;
        e.kind = -1; e.vec = '0; e.cyc = -1; e.hash = '0;
        e.hv = 1'b0; e.ar = 1'b0; e.own = '0; e.bsy = 1'b0;
        while (!ok && n <= budget) begin
            while (ev_q.size() > 0 && !ok) begin
                e = ev_q.pop_front();
                if (e.kind == kind) ok = 1'b1;
            end
            if (!ok) begin
                @(negedge clk); #2;
                n++;
            end
        end
    endtask

    task automatic test_reset();
        logic [18:0] v;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        v = {gnt, done, err, busy, owner, hash_valid, acc_start, acc_reset, mem_read};
        tests_run++;
        if (v !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, want 0", v);
        end
        tests_run++;
        if (hash_out !== '0 || mem_addr !== '0) begin
            tests_failed++;
            $display("FAIL reset_hash_addr: got hash=%h addr=%h, want 0/0", hash_out, mem_addr);
        end
        @(negedge clk); #2 reset = 1'b1;
        model_last = N_REQ - 1;
        model_hash = '0;
    endtask

    task automatic test_single();
        ev_t g, s, d;
        bit  ok;
        int  c;
        acc_mode = 0; fixed_words = 1'b1;
        addr_q.delete(); ev_q.delete();
        @(negedge clk); #2;
        req = 4'b0010; c = cyc;
        wait_ev(K_GNT, 10, g, ok);
        tests_run++;
        if (!ok || g.vec !== 4'b0010 || g.cyc !== c + 1 || g.own !== 2'd1 || g.bsy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_gnt: got ok=%0d vec=%b cyc=%0d own=%0d busy=%b, want vec=0010 cyc=%0d own=1 busy=1",
                     ok, g.vec, g.cyc, g.own, g.bsy, c + 1);
        end
        wait_ev(K_START, 10, s, ok);
        tests_run++;
        if (!ok || s.cyc !== c + 2) begin
            tests_failed++;
            $display("FAIL single_start: got ok=%0d cyc=%0d, want cyc=%0d", ok, s.cyc, c + 2);
        end
        wait_ev(K_DONE, 60, d, ok);
        req = 4'b0000;
        tests_run++;
        if (!ok || d.vec !== 4'b0010 || d.hv !== 1'b1 || d.cyc !== s.cyc + job_last_r + 1
            || d.hash !== 128'h11111111_22222222_33333333_44444444) begin
            tests_failed++;
            $display("FAIL single_done: got ok=%0d vec=%b hv=%b cyc=%0d hash=%h, want vec=0010 hv=1 cyc=%0d hash=11111111222222223333333344444444",
                     ok, d.vec, d.hv, d.cyc, d.hash, s.cyc + job_last_r + 1);
        end
        for (int k = 0; k < 16; k++) begin
            tests_run++;
            if (k >= addr_q.size() || addr_q[k] !== 6'(16 + k)) begin
                tests_failed++;
                $display("FAIL single_mem_addr[%0d]: got %h (of %0d reads), want %h",
                         k, (k < addr_q.size()) ? addr_q[k] : 6'h3f, addr_q.size(), 6'(16 + k));
            end
        end
        repeat (3) @(negedge clk);
        #2;
        tests_run++;
        if (mem_addr !== 6'h10 || mem_read !== 1'b0 || hash_valid !== 1'b0
            || hash_out !== 128'h11111111_22222222_33333333_44444444) begin
            tests_failed++;
            $display("FAIL single_idle: got addr=%h rd=%b hv=%b hash=%h, want addr=10 rd=0 hv=0 hash held",
                     mem_addr, mem_read, hash_valid, hash_out);
        end
        fixed_words = 1'b0;
        model_last  = 1;
        model_hash  = 128'h11111111_22222222_33333333_44444444;
    endtask

    task automatic test_rr_order();
        ev_t g, d;
        bit  ok;
        int  exp;
        int  prev_done = 0;
        @(negedge clk); #2 reset = 1'b0;
        @(negedge clk); #2 reset = 1'b1;
        model_last = N_REQ - 1;
        ev_q.delete();
        req = 4'b1011;
        for (int j = 0; j < 4; j++) begin
            exp = rr_pick(model_last, 4'b1011);
            wait_ev(K_GNT, 10, g, ok);
            tests_run++;
            if (!ok || g.vec !== (4'b0001 << exp) || (j > 0 && g.cyc !== prev_done + 2)) begin
                tests_failed++;
                $display("FAIL rr_order_gnt[%0d]: got ok=%0d vec=%b cyc=%0d, want id=%0d cyc=%0d",
                         j, ok, g.vec, g.cyc, exp, prev_done + 2);
            end
            if (j == 3) req = 4'b0000;
            wait_ev(K_DONE, 60, d, ok);
            tests_run++;
            if (!ok || d.vec !== (4'b0001 << exp) || d.hash !== exp_digest) begin
                tests_failed++;
                $display("FAIL rr_order_done[%0d]: got ok=%0d vec=%b hash=%h, want id=%0d hash=%h",
                         j, ok, d.vec, d.hash, exp, exp_digest);
            end
            prev_done  = d.cyc;
            model_last = exp;
            model_hash = exp_digest;
        end
        repeat (4) @(negedge clk);
        #2;
        tests_run++;
        if (ev_q.size() != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_order_quiet: got %0d events busy=%b, want 0 events busy=0", ev_q.size(), busy);
        end
    endtask

    task automatic test_wait_busy();
        ev_t g, s, d;
        bit  ok;
        int  gnt_before;
        ev_q.delete();
        req = 4'b0100;
        wait_ev(K_GNT, 10, g, ok);
        wait_ev(K_START, 10, s, ok);
        req = 4'b0101;
        gnt_before = gnt_total;
        wait_ev(K_DONE, 60, d, ok);
        req = 4'b0001;
        tests_run++;
        if (!ok || d.vec !== 4'b0100 || gnt_total != gnt_before) begin
            tests_failed++;
            $display("FAIL wait_busy_done2: got ok=%0d vec=%b extra_gnts=%0d, want vec=0100 extra_gnts=0",
                     ok, d.vec, gnt_total - gnt_before);
        end
        model_last = 2;
        model_hash = exp_digest;
        wait_ev(K_GNT, 10, g, ok);
        tests_run++;
        if (!ok || g.vec !== 4'b0001 || g.cyc !== d.cyc + 2) begin
            tests_failed++;
            $display("FAIL wait_busy_gnt0: got ok=%0d vec=%b cyc=%0d, want vec=0001 cyc=%0d",
                     ok, g.vec, g.cyc, d.cyc + 2);
        end
        wait_ev(K_DONE, 60, d, ok);
        req = 4'b0000;
        model_last = 0;
        model_hash = exp_digest;
    endtask

    task automatic test_timeout();
        ev_t g, s, e, d;
        bit  ok;
        int  id;
        int  done_before;
        logic [127:0] prev;
        prev = model_hash;
        acc_mode = 1;
        ev_q.delete();
        id = int'($urandom_range(0, 3));
        req = 4'b0001 << id;
        done_before = done_total;
        wait_ev(K_GNT, 10, g, ok);
        wait_ev(K_START, 10, s, ok);
        wait_ev(K_ERR, TIMEOUT + 10, e, ok);
        req = 4'b0000;
        tests_run++;
        if (!ok || e.vec !== (4'b0001 << id) || e.cyc !== s.cyc + TIMEOUT + 1 || e.ar !== 1'b1 || e.hv !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_err: got ok=%0d vec=%b cyc=%0d acc_reset=%b hv=%b, want id=%0d cyc=%0d acc_reset=1 hv=0",
                     ok, e.vec, e.cyc, e.ar, e.hv, id, s.cyc + TIMEOUT + 1);
        end
        tests_run++;
        if (e.hash !== prev || done_total != done_before) begin
            tests_failed++;
            $display("FAIL timeout_hash_kept: got hash=%h dones=%0d, want hash=%h dones=0",
                     e.hash, done_total - done_before, prev);
        end
        model_last = id;
        acc_mode = 0;
        repeat (2) @(negedge clk);
        #2;
        id = int'($urandom_range(0, 3));
        req = 4'b0001 << id;
        wait_ev(K_DONE, 80, d, ok);
        req = 4'b0000;
        tests_run++;
        if (!ok || d.vec !== (4'b0001 << id) || d.hash !== exp_digest) begin
            tests_failed++;
            $display("FAIL timeout_recover: got ok=%0d vec=%b hash=%h, want id=%0d hash=%h",
                     ok, d.vec, d.hash, id, exp_digest);
        end
        model_last = id;
        model_hash = exp_digest;
    endtask

    task automatic test_late();
        ev_t g, s, d;
        bit  ok;
        int  exp;
        int  err_before;
        logic [3:0] pat;
        acc_mode = 2;
        ev_q.delete();
        pat = 4'($urandom_range(1, 15));
        exp = rr_pick(model_last, pat);
        err_before = err_total;
        req = pat;
        wait_ev(K_GNT, 10, g, ok);
        wait_ev(K_START, 10, s, ok);
        wait_ev(K_DONE, TIMEOUT + 10, d, ok);
        req = 4'b0000;
        tests_run++;
        if (!ok || d.vec !== (4'b0001 << exp) || d.cyc !== s.cyc + TIMEOUT + 1 || d.hash !== exp_digest) begin
            tests_failed++;
            $display("FAIL late_done: got ok=%0d vec=%b cyc=%0d hash=%h, want id=%0d cyc=%0d hash=%h",
                     ok, d.vec, d.cyc, d.hash, exp, s.cyc + TIMEOUT + 1, exp_digest);
        end
        model_last = exp;
        model_hash = exp_digest;
        repeat (4) @(negedge clk);
        #2;
        tests_run++;
        if (err_total != err_before || hash_out !== exp_digest || hash_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL late_extra_ignored: got errs=%0d hash=%h hv=%b, want errs=0 hash=%h hv=0",
                     err_total - err_before, hash_out, hash_valid, exp_digest);
        end
        acc_mode = 0;
    endtask

    task automatic test_reset_mid();
        ev_t g, s, d;
        bit  ok;
        int  exp;
        int  c;
        logic [18:0] v;
        logic [3:0]  pat;
        ev_q.delete();
        req = 4'b1000;
        wait_ev(K_GNT, 10, g, ok);
        wait_ev(K_START, 10, s, ok);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        v = {gnt, done, err, busy, owner, hash_valid, acc_start, acc_reset, mem_read};
        tests_run++;
        if (v !== '0 || hash_out !== '0 || mem_addr !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got ctl=%h hash=%h addr=%h, want all 0", v, hash_out, mem_addr);
        end
        pat = 4'($urandom_range(1, 15));
        req = pat;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        c = cyc;
        model_last = N_REQ - 1;
        model_hash = '0;
        ev_q.delete();
        exp = rr_pick(model_last, pat);
        wait_ev(K_GNT, 10, g, ok);
        tests_run++;
        if (!ok || g.vec !== (4'b0001 << exp) || g.cyc !== c + 1) begin
            tests_failed++;
            $display("FAIL reset_mid_regrant: got ok=%0d vec=%b cyc=%0d, want id=%0d cyc=%0d",
                     ok, g.vec, g.cyc, exp, c + 1);
        end
        wait_ev(K_DONE, 60, d, ok);
        req = 4'b0000;
        model_last = exp;
        model_hash = exp_digest;
    endtask

    task automatic test_random();
        ev_t g, d;
        bit  ok;
        int  exp;
        int  c;
        int  prev_done = 0;
        logic [3:0] pat;
        repeat (2) @(negedge clk);
        #2;
        ev_q.delete();
        pat = 4'($urandom_range(1, 15));
        req = pat;
        c = cyc;
        for (int j = 0; j < 8; j++) begin
            exp = rr_pick(model_last, pat);
            wait_ev(K_GNT, 10, g, ok);
            tests_run++;
            if (!ok || g.vec !== (4'b0001 << exp) || g.cyc !== ((j == 0) ? c + 1 : prev_done + 2)) begin
                tests_failed++;
                $display("FAIL random_gnt[%0d]: got ok=%0d vec=%b cyc=%0d, want id=%0d cyc=%0d (req=%b)",
                         j, ok, g.vec, g.cyc, exp, (j == 0) ? c + 1 : prev_done + 2, pat);
            end
            if ($urandom_range(0, 3) == 0) req = 4'b0000;
            wait_ev(K_DONE, 60, d, ok);
            tests_run++;
            if (!ok || d.vec !== (4'b0001 << exp) || d.hash !== exp_digest || d.hv !== 1'b1) begin
                tests_failed++;
                $display("FAIL random_done[%0d]: got ok=%0d vec=%b hv=%b hash=%h, want id=%0d hv=1 hash=%h",
                         j, ok, d.vec, d.hv, d.hash, exp, exp_digest);
            end
            model_last = exp;
            model_hash = exp_digest;
            prev_done  = d.cyc;
            pat = 4'($urandom_range(1, 15));
            req = (j == 7) ? 4'b0000 : pat;
        end
    endtask

    initial begin
        req          = '0;
        acc_msg_addr = '0;
        acc_mem_read = 1'b0;
        acc_hash     = '0;
        acc_valid    = 1'b0;
        test_reset();
        test_single();
        test_rr_order();
        test_wait_busy();
        test_timeout();
        test_late();
        test_reset_mid();
        test_random();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1, "bench time limit reached");
    end

endmodule
